decrypted_message_reader: RTL and testbench

Reads the plaintext that the `arcfour` key-search core has written into the decrypted-message RAM and streams it out as a byte frame over a valid/ready interface. The frame carries the recovered key followed by the message. The block is the read-side counterpart of the core's `aAddr`/`aIn`/`aWren` write port and sits between that RAM and a downstream consumer such as a UART or display driver. It starts on the core's `terminated` rising edge. If the search failed, it reports `failed` instead of sending a frame.

---
 rtl/decrypted_message_reader_if.sv | 12 +
 rtl/decrypted_message_reader.sv | 165 ++++++++++++++++
 tb/tb_decrypted_message_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypted_message_reader_if.sv
// Byte-stream handshake bundle carrying the recovered frame out of the reader.
interface decrypted_message_reader_if #(
  parameter int RAM_WIDTH = 8
);
  logic [RAM_WIDTH-1:0] oData;
  logic                 oValid;
  logic                 oReady;
  logic                 oLast;

  modport master (output oData, output oValid, output oLast, input oReady);
  modport slave  (input oData, input oValid, input oLast, output oReady);
endinterface

// File: rtl/decrypted_message_reader.sv
// Streams the recovered key followed by the decrypted message RAM contents
// as one valid/ready byte frame, or raises a sticky failure flag when the
// key search ends without success.
module decrypted_message_reader #(
  parameter int RAM_WIDTH          = 8,
  parameter int KEY_LENGTH         = 3,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          terminated,
  input  logic                          succeeded,
  input  logic [KEY_LENGTH*8-1:0]       key,
  output logic [MESSAGE_LOG_LENGTH-1:0] aAddr,
  input  logic [RAM_WIDTH-1:0]          aOut,
  decrypted_message_reader_if.master    stream,
  output logic                          busy,
  output logic                          done,
  output logic                          failed
);

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [KIDX_W-1:0]             KIDX_LAST = KIDX_W'(KEY_LENGTH - 1);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] IDX_LAST  = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  typedef enum logic [2:0] {IDLE, KEY, FETCH, CAPTURE, SEND, DONE} state_t;

  state_t                        state, state_n;
  logic                          term_q;
  logic [KEY_LENGTH*8-1:0]       key_q, key_n;
  logic [MESSAGE_LOG_LENGTH-1:0] idx, idx_n;
  logic [KIDX_W-1:0]             kidx, kidx_n;
  logic [RAM_WIDTH-1:0]          data_q, data_n;
  logic                          valid_q, valid_n;
  logic                          last_q, last_n;
  logic [MESSAGE_LOG_LENGTH-1:0] addr_q, addr_n;
  logic                          busy_q, busy_n;
  logic                          failed_q, failed_n;
  logic [7:0]                    key_byte_n;

  logic trigger, handshake, last_msg;

  assign trigger   = terminated && !term_q && (state == IDLE);
  assign handshake = valid_q && stream.oReady;
  assign last_msg  = (idx == IDX_LAST);

  assign stream.oData  = data_q;
  assign stream.oValid = valid_q;
  assign stream.oLast  = last_q;
  assign aAddr         = addr_q;
  assign busy          = busy_q;
  assign failed        = failed_q;
  assign done          = (state == DONE);

  // Next key byte to present, counting down from the MSB byte
  always_comb begin
    key_byte_n = '0;
    for (int unsigned b = 0; b < KEY_LENGTH; b++) begin
      if (b == 32'(kidx) + 32'd1) key_byte_n = key_q[(KEY_LENGTH-1-b)*8 +: 8];
    end
  end

  // State register plus all registered stream/RAM outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      term_q   <= 1'b0;
      key_q    <= '0;
      idx      <= '0;
      kidx     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state    <= state_n;
      term_q   <= terminated;
      key_q    <= key_n;
      idx      <= idx_n;
      kidx     <= kidx_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      last_q   <= last_n;
      addr_q   <= addr_n;
      busy_q   <= busy_n;
      failed_q <= failed_n;
    end
  end

  // Next-state sequencing: key bytes, then fetch/capture/send per message byte
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (trigger) state_n = succeeded ? KEY : DONE;
      KEY:     if (handshake && (kidx == KIDX_LAST)) state_n = FETCH;
      FETCH:   state_n = CAPTURE;
      CAPTURE: state_n = SEND;
      SEND:    if (handshake) state_n = last_msg ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    key_n    = key_q;
    idx_n    = idx;
    kidx_n   = kidx;
    data_n   = data_q;
    valid_n  = valid_q;
    last_n   = last_q;
    addr_n   = addr_q;
    busy_n   = busy_q;
    failed_n = failed_q;
    case (state)
      IDLE: begin
        if (trigger) begin
          key_n    = key;
          idx_n    = '0;
          kidx_n   = '0;
          busy_n   = 1'b1;
          failed_n = !succeeded;
          if (succeeded) begin
            valid_n = 1'b1;
            data_n  = RAM_WIDTH'(key[KEY_LENGTH*8-1 -: 8]);
          end
        end
      end
      KEY: begin
        if (handshake) begin
          if (kidx == KIDX_LAST) begin
            valid_n = 1'b0;
            // Address is also loaded here so a new frame starts at word 0
            // regardless of where the previous frame left it.
            addr_n  = idx;
          end else begin
            kidx_n = kidx + KIDX_W'(1);
            data_n = RAM_WIDTH'(key_byte_n);
          end
        end
      end
      CAPTURE: begin
        data_n  = aOut;
        valid_n = 1'b1;
        last_n  = last_msg;
      end
      SEND: begin
        if (handshake) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          if (!last_msg) begin
            idx_n  = idx + MESSAGE_LOG_LENGTH'(1);
            addr_n = idx + MESSAGE_LOG_LENGTH'(1);
          end
        end
      end
      DONE: busy_n = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decrypted_message_reader.sv
// Randomized bench for decrypted_message_reader: the expected frame is
// built as a byte queue (key MSB-first, then RAM words) and compared with
// every accepted byte; stalls must hold the stream stable.
module tb_decrypted_message_reader;

  localparam int RW = 8;
  localparam int KL = 3;
  localparam int ML = 32;
  localparam int LL = 5;
  localparam int KW = KL * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          terminated = 1'b0;
  logic          succeeded = 1'b0;
  logic [KW-1:0] key = '0;
  logic [LL-1:0] aAddr;
  logic [RW-1:0] aOut;
  logic          busy, done, failed;
  logic [RW-1:0] ram [ML];

  decrypted_message_reader_if #(.RAM_WIDTH(RW)) stream ();

  decrypted_message_reader #(
    .RAM_WIDTH(RW), .KEY_LENGTH(KL), .MESSAGE_LENGTH(ML), .MESSAGE_LOG_LENGTH(LL)
  ) dut (
    .clk(clk), .reset(reset), .terminated(terminated), .succeeded(succeeded),
    .key(key), .aAddr(aAddr), .aOut(aOut), .stream(stream),
    .busy(busy), .done(done), .failed(failed)
  );

  always #5 clk = ~clk;

  // Message RAM with one cycle of read latency
  always @(posedge clk) aOut <= ram[aAddr];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  int         rx_count = 0;
  int         extra = 0;
  int         done_count = 0;
  bit         stall_pending = 0;
  logic [7:0] held_data;
  logic       held_last;
  bit         rand_ready = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready driver: always ready, or a random pattern
  initial begin
    stream.oReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      stream.oReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: scoreboard against exp_q and stall stability
  initial begin
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_pending = 0;
      end else begin
        if (stall_pending) begin
          check("stall_valid", stream.oValid, 1'b1);
          check("stall_data", stream.oData, held_data);
          check("stall_last", stream.oLast, held_last);
        end
        if (stream.oValid && stream.oReady) begin
          stall_pending = 0;
          rx_count++;
          if (exp_q.size() == 0) extra++;
          else begin
            exp_byte = exp_q.pop_front();
            check($sformatf("byte%0d", rx_count), stream.oData, exp_byte);
            check($sformatf("last%0d", rx_count), stream.oLast, exp_q.size() == 0);
          end
        end else if (stream.oValid) begin
          stall_pending = 1;
          held_data = stream.oData;
          held_last = stream.oLast;
        end else begin
          stall_pending = 0;
        end
        if (done) done_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input logic [KW-1:0] k, input bit pattern);
    key = k;
    for (int i = 0; i < ML; i++) ram[i] = pattern ? RW'(32'h41 + i) : RW'($urandom);
    exp_q.delete();
    for (int b = KL - 1; b >= 0; b--) exp_q.push_back(k[b*8 +: 8]);
    for (int i = 0; i < ML; i++) exp_q.push_back(ram[i]);
    rx_count = 0;
    extra = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oValid"}, stream.oValid, 1'b0);
    check({tag, "_oData"}, stream.oData, 0);
    check({tag, "_oLast"}, stream.oLast, 1'b0);
    check({tag, "_aAddr"}, aAddr, 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_failed"}, failed, 1'b0);
  endtask

  // Called at the first negedge after the trigger edge
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic finish_frame(input string tag, input int dc0, input bit timing, input int cyc);
    if (timing) check({tag, "_cycles"}, cyc, KL + 3 * ML);
    check({tag, "_count"}, rx_count, KL + ML);
    check({tag, "_extra"}, extra, 0);
    check({tag, "_failed"}, failed, 1'b0);
    @(negedge clk);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_done_count"}, done_count - dc0, 1);
  endtask

  task automatic run_success(input string tag, input bit timing);
    int cyc;
    int dc0;
    dc0 = done_count;
    terminated = 1'b0;
    @(posedge clk);
    #1;
    succeeded = 1'b1;
    terminated = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_first_valid"}, stream.oValid, 1'b1);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_failed_clear"}, failed, 1'b0);
    wait_done(tag, cyc);
    finish_frame(tag, dc0, timing, cyc);
  endtask

  initial begin
    int dc0;
    int cyc;
    int guard;

    for (int i = 0; i < ML; i++) ram[i] = '0;
    repeat (15) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_values("idle");

    // Plain frame, full-rate ready
    load_frame(24'h490200, 1);
    run_success("frame", 1);

    // terminated held high: no second frame
    dc0 = done_count;
    repeat (500) @(negedge clk);
    check("hold_extra", extra, 0);
    check("hold_count", rx_count, KL + ML);
    check("hold_done", done_count - dc0, 0);
    check("hold_busy", busy, 1'b0);

    // Drop and re-raise: identical frame
    load_frame(24'h490200, 1);
    run_success("retrig", 1);

    // Backpressure
    rand_ready = 1;
    load_frame(24'h490200, 1);
    run_success("bp_fixed", 0);
    for (int f = 0; f < 3; f++) begin
      load_frame(KW'($urandom), 0);
      run_success($sformatf("bp_rand%0d", f), 0);
    end

    // Failed search
    load_frame(KW'($urandom), 0);
    exp_q.delete();
    dc0 = done_count;
    terminated = 1'b0;
    @(posedge clk);
    #1;
    succeeded = 1'b0;
    terminated = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fail_done", done, 1'b1);
    check("fail_flag", failed, 1'b1);
    check("fail_valid", stream.oValid, 1'b0);
    @(negedge clk);
    check("fail_done_end", done, 1'b0);
    check("fail_busy_end", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("fail_sticky", failed, 1'b1);
    check("fail_no_bytes", rx_count, 0);
    check("fail_done_count", done_count - dc0, 1);
    load_frame(KW'($urandom), 0);
    run_success("after_fail", 0);

    // Reset during message byte 10; terminated stays high and retriggers
    rand_ready = 0;
    load_frame(KW'($urandom), 0);
    dc0 = done_count;
    terminated = 1'b0;
    @(posedge clk);
    #1;
    succeeded = 1'b1;
    terminated = 1'b1;
    guard = 0;
    while (!(rx_count == KL + 10 && stream.oValid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reach", rx_count, KL + 10);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_rst");
    check("mid_no_done", done_count - dc0, 0);
    load_frame(KW'($urandom), 0);
    dc0 = done_count;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("restart_valid", stream.oValid, 1'b1);
    check("restart_busy", busy, 1'b1);
    wait_done("restart", cyc);
    finish_frame("restart", dc0, 1, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
